// File: rtl/bc_pkg.sv
// Glyph codes and seven-segment encodings shared by the Bulls & Cows datapath.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package bc_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t GLYPH_BLANK = 5'd16;
    localparam glyph_t GLYPH_L     = 5'd17;
    localparam glyph_t GLYPH_U     = 5'd18;
    localparam glyph_t GLYPH_P     = 5'd19;
    localparam glyph_t GLYPH_R     = 5'd20;
    localparam glyph_t GLYPH_N     = 5'd21;
    localparam glyph_t GLYPH_O     = 5'd22;
    localparam glyph_t GLYPH_DASH  = 5'd23;
    localparam glyph_t GLYPH_H     = 5'd24;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_O     = 7'h23;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_H     = 7'h09;

    // Unassigned codes (25..31) fall through to blank so stray values stay dark.
    function automatic logic [6:0] seg7_of(input glyph_t g);
        logic [6:0] s;
        case (g)
            5'd0:        s = 7'h40;
            5'd1:        s = 7'h79;
            5'd2:        s = 7'h24;
            5'd3:        s = 7'h30;
            5'd4:        s = 7'h19;
            5'd5:        s = 7'h12;
            5'd6:        s = 7'h02;
            5'd7:        s = 7'h78;
            5'd8:        s = 7'h00;
            5'd9:        s = 7'h10;
            5'd10:       s = 7'h08;
            5'd11:       s = 7'h03;
            5'd12:       s = 7'h46;
            5'd13:       s = 7'h21;
            5'd14:       s = 7'h06;
            5'd15:       s = 7'h0E;
            GLYPH_L:     s = SEG_L;
            GLYPH_U:     s = SEG_U;
            GLYPH_P:     s = SEG_P;
            GLYPH_R:     s = SEG_R;
            GLYPH_N:     s = SEG_N;
            GLYPH_O:     s = SEG_O;
            GLYPH_DASH:  s = SEG_DASH;
            GLYPH_H:     s = SEG_H;
            default:     s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-to-segment lookup used on the scanner's muxed glyph.
module seg7_decode
    import bc_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);

    // Pure table lookup, no state.
    always_comb begin
        seg = seg7_of(glyph);
    end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexes eight glyphs onto an 8-digit common-anode display.
// New data is held in a shadow copy and only moves to the visible copy at the
// digit 7 -> digit 0 wrap, so a frame is never drawn from two different loads.
module seg7_scanner
    import bc_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLINK_FRAMES = 62
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] chars_in,
    input  logic [7:0]  blink_in,
    output logic        pending,
    output logic        frame_tick,
    output logic [7:0]  an,
    output logic [6:0]  digit
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [39:0]   CHARS_BLANK = {8{GLYPH_BLANK}};

    logic [PW-1:0] prescale;
    logic [2:0]    scan_idx;
    logic          tc;
    logic          commit_slot;

    logic [39:0]   active_chars;
    logic [39:0]   shadow_chars;
    logic [7:0]    active_blink;
    logic [7:0]    shadow_blink;
    logic          pending_q;

    logic [BW-1:0] frame_cnt;
    logic          blink_phase;

    logic [4:0]    cur_glyph;
    logic [6:0]    cur_seg;
    logic          slot_off;

    logic [7:0]    an_q;
    logic [6:0]    digit_q;
    logic          tick_q;

    // Slot timing and the glyph currently selected by the scan index.
    always_comb begin
        tc          = (prescale == PRE_LAST);
        commit_slot = tc && (scan_idx == 3'd7);
        cur_glyph   = active_chars[scan_idx*5 +: 5];
        slot_off    = blink_phase && active_blink[scan_idx];
    end

    seg7_decode u_decode (
        .glyph (cur_glyph),
        .seg   (cur_seg)
    );

    // Free-running prescaler and scan index; load never disturbs them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            scan_idx <= 3'd0;
        end else begin
            if (tc) begin
                prescale <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    // Double buffer: a load landing exactly on the commit slot bypasses the
    // shadow so it is neither lost nor delayed a whole frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_chars <= CHARS_BLANK;
            shadow_chars <= CHARS_BLANK;
            active_blink <= 8'h00;
            shadow_blink <= 8'h00;
            pending_q    <= 1'b0;
        end else begin
            if (load) begin
                shadow_chars <= chars_in;
                shadow_blink <= blink_in;
            end
            if (commit_slot) begin
                pending_q <= 1'b0;
                if (load) begin
                    active_chars <= chars_in;
                    active_blink <= blink_in;
                end else if (pending_q) begin
                    active_chars <= shadow_chars;
                    active_blink <= shadow_blink;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES complete frames.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (commit_slot) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Registered pad drivers; reset blanks the display asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_q    <= 8'hFF;
            digit_q <= SEG_BLANK;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= commit_slot;
            if (slot_off) begin
                an_q    <= 8'hFF;
                digit_q <= SEG_BLANK;
            end else begin
                an_q    <= ~(8'h01 << scan_idx);
                digit_q <= cur_seg;
            end
        end
    end

    assign an         = an_q;
    assign digit      = digit_q;
    assign frame_tick = tick_q;
    assign pending    = pending_q;

endmodule
